// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART TX state encoding, default width, even-parity helper (ST_PAR only with UART_TX_PARITY_EN)
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd5;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PAR   = 3'd4;
`endif

   function automatic logic evenParity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// rtl/uart_tx_rr_arb.sv - two-way round-robin arbiter, pointer resets to B so A wins first contention
module uart_tx_rr_arb (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iReq_a,
   input  logic       iReq_b,
   input  logic       iEn,
   output logic [1:0] oGrant
);

   logic lastB;

   always_comb begin
      oGrant = 2'b00;
      if (iEn) begin
         if (iReq_a && (!iReq_b || lastB))
            oGrant = 2'b01;
         else if (iReq_b)
            oGrant = 2'b10;
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst)
         lastB <= 1'b1;
      else if (oGrant[0])
         lastB <= 1'b0;
      else if (oGrant[1])
         lastB <= 1'b1;
   end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART TX frame sequencer shared by two requesters; UART_TX_PARITY_EN adds even parity bit
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iBaud_tick,
   input  logic                 iReq_a,
   input  logic [DATA_BITS-1:0] iData_a,
   input  logic                 iReq_b,
   input  logic [DATA_BITS-1:0] iData_b,
   output logic                 oAck_a,
   output logic                 oAck_b,
   output logic                 oTx,
   output logic                 oBusy
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   logic [2:0]           state;
   logic [DATA_BITS-1:0] dataReg;
   logic [DATA_BITS-1:0] winData;
   logic [CNT_W-1:0]     bitCnt;
   logic [CNT_W-1:0]     nextCnt;
   logic [1:0]           grant;
   logic                 arbEn;

   // Arbitration only happens when a new frame may start: idle, or the stop-bit tick
   assign arbEn   = (state == ST_IDLE) || ((state == ST_STOP) && iBaud_tick);
   assign winData = grant[0] ? iData_a : iData_b;
   assign nextCnt = bitCnt + 1'b1;

   uart_tx_rr_arb uArb (
      .iClk   (iClk),
      .iRst   (iRst),
      .iReq_a (iReq_a),
      .iReq_b (iReq_b),
      .iEn    (arbEn),
      .oGrant (grant)
   );

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state   <= ST_IDLE;
         dataReg <= '0;
         bitCnt  <= '0;
         oTx     <= 1'b1;
         oBusy   <= 1'b0;
         oAck_a  <= 1'b0;
         oAck_b  <= 1'b0;
      end else begin
         oAck_a <= grant[0];
         oAck_b <= grant[1];
         if (|grant)
            dataReg <= winData;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  oBusy <= 1'b1;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (iBaud_tick) begin
                  oTx   <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (iBaud_tick) begin
                  oTx    <= dataReg[0];
                  bitCnt <= '0;
                  state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (iBaud_tick) begin
                  if (bitCnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     oTx   <= evenParity(32'(dataReg));
                     state <= ST_PAR;
`else
                     oTx   <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     bitCnt <= nextCnt;
                     oTx    <= dataReg[nextCnt];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PAR: begin
               if (iBaud_tick) begin
                  oTx   <= 1'b1;
                  state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               // A waiting byte starts immediately so back-to-back frames have no idle gap
               if (iBaud_tick) begin
                  if (|grant) begin
                     oTx   <= 1'b0;
                     state <= ST_START;
                  end else begin
                     oBusy <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               oTx   <= 1'b1;
               oBusy <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched; parity checks active when UART_TX_PARITY_EN is defined
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int BIT_CYC = 16;

   logic       iClk = 1'b0;
   logic       iRst = 1'b0;
   logic       iBaud_tick = 1'b0;
   logic       iReq_a = 1'b0;
   logic [7:0] iData_a = 8'h00;
   logic       iReq_b = 1'b0;
   logic [7:0] iData_b = 8'h00;
   logic       oAck_a;
   logic       oAck_b;
   logic       oTx;
   logic       oBusy;

   int         nCompared = 0;
   int         nMismatched = 0;
   int         cyc = 0;
   int         framesDone = 0;
   int         nAck = 0;
   int         lastAckCyc = 0;
   logic       lastPar = 1'b0;
   logic [7:0] expQ[$];
   int         startQ[$];
   logic       ackOrder[$];

   uart_tx_sched #(.DATA_BITS(8)) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iBaud_tick (iBaud_tick),
      .iReq_a     (iReq_a),
      .iData_a    (iData_a),
      .iReq_b     (iReq_b),
      .iData_b    (iData_b),
      .oAck_a     (oAck_a),
      .oAck_b     (oAck_b),
      .oTx        (oTx),
      .oBusy      (oBusy)
   );

   initial forever #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      assert (obs === expv)
      else begin
         nMismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cycCount();
      forever begin
         @(posedge iClk);
         cyc++;
      end
   endtask

   task automatic tickGen();
      int tickCnt = 0;
      forever begin
         @(negedge iClk);
         tickCnt = (tickCnt + 1) % BIT_CYC;
         iBaud_tick = (tickCnt == 0);
      end
   endtask

   task automatic ackMon();
      forever begin
         @(negedge iClk);
         if (oAck_a === 1'b1) begin ackOrder.push_back(1'b0); nAck++; end
         if (oAck_b === 1'b1) begin ackOrder.push_back(1'b1); nAck++; end
      end
   endtask

   // Line decoder: samples the middle of each bit period and checks every bit is held steady
   task automatic lineMon();
      logic       active = 1'b0;
      logic       bitVal = 1'b1;
      logic       glitch = 1'b0;
      logic       startBit = 1'b1;
      logic       stopBit = 1'b0;
      logic       parBit = 1'b0;
      logic [7:0] rx = 8'h00;
      logic [7:0] expv;
      int         off = 0;
      int         k;
      int         r;
      int         sCyc = 0;
      forever begin
         @(negedge iClk);
         if (!iRst) begin
            if (active && expQ.size() > 0) void'(expQ.pop_front());
            active = 1'b0;
         end else if (!active) begin
            if (oTx === 1'b0) begin
               active = 1'b1; off = 0; sCyc = cyc; glitch = 1'b0; bitVal = oTx;
            end
         end else begin
            off++;
            k = off / BIT_CYC;
            r = off % BIT_CYC;
            if (r == 0) bitVal = oTx;
            else if (oTx !== bitVal) glitch = 1'b1;
            if (r == 8) begin
               if (k == 0) startBit = oTx;
               else if (k <= 8) rx[3'(k - 1)] = oTx;
`ifdef UART_TX_PARITY_EN
               else if (k == 9) parBit = oTx;
`endif
               if (k == FRAME - 1) begin
                  stopBit = oTx;
                  active = 1'b0;
                  chk("frame_expected", 32'(expQ.size() > 0), 1);
                  if (expQ.size() > 0) begin
                     expv = expQ.pop_front();
                     chk("start_bit", 32'(startBit), 0);
                     chk("data_byte", 32'(rx), 32'(expv));
                     chk("stop_bit", 32'(stopBit), 1);
                     chk("bit_hold", 32'(glitch), 0);
`ifdef UART_TX_PARITY_EN
                     chk("parity_bit", 32'(parBit), 32'(^expv));
                     lastPar = parBit;
`endif
                  end
                  startQ.push_back(sCyc);
                  framesDone++;
               end
            end
         end
      end
   endtask

   task automatic sendOne(input logic isB, input logic [7:0] d);
      logic got = 1'b0;
      @(negedge iClk);
      if (isB) begin iReq_b = 1'b1; iData_b = d; end
      else begin iReq_a = 1'b1; iData_a = d; end
      expQ.push_back(d);
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge iClk);
         if ((isB ? oAck_b : oAck_a) === 1'b1) got = 1'b1;
      end
      lastAckCyc = cyc;
      chk("ack_seen", 32'(got), 1);
      chk("busy_at_ack", 32'(oBusy), 1);
      if (isB) iReq_b = 1'b0; else iReq_a = 1'b0;
      @(negedge iClk);
      chk("ack_single_pulse", 32'(isB ? oAck_b : oAck_a), 0);
   endtask

   task automatic waitFrames(input int target);
      for (int i = 0; i < BIT_CYC * FRAME * 5 + 100 && framesDone < target; i++)
         @(negedge iClk);
      chk("frames_done", 32'(framesDone), 32'(target));
   endtask

   task automatic doReset();
      @(negedge iClk);
      #2 iRst = 1'b0;
      repeat (3) @(negedge iClk);
      iRst = 1'b1;
   endtask

   initial begin
      logic [7:0] aData[2];
      logic [7:0] bData[2];
      int idxA;
      int idxB;
      int lat;
      int base;
      logic got;
      fork
         cycCount();
         tickGen();
         ackMon();
         lineMon();
      join_none

      repeat (3) @(negedge iClk);
      chk("reset_tx", 32'(oTx), 1);
      chk("reset_busy", 32'(oBusy), 0);
      chk("reset_ack_a", 32'(oAck_a), 0);
      chk("reset_ack_b", 32'(oAck_b), 0);
      iRst = 1'b1;

      repeat (50) @(negedge iClk);
      chk("idle_tx", 32'(oTx), 1);
      chk("idle_busy", 32'(oBusy), 0);
      chk("idle_no_ack", 32'(nAck), 0);

      sendOne(1'b0, 8'h55);
      waitFrames(1);
      lat = startQ[0] - lastAckCyc;
      chk("start_latency", 32'(lat >= 1 && lat <= BIT_CYC), 1);
      repeat (BIT_CYC) @(negedge iClk);
      chk("busy_after_stop", 32'(oBusy), 0);
      chk("tx_after_stop", 32'(oTx), 1);

      doReset();
      @(negedge iClk);
      iReq_a = 1'b1; iData_a = 8'h41;
      iReq_b = 1'b1; iData_b = 8'h42;
      expQ.push_back(8'h41);
      expQ.push_back(8'h42);
      for (int i = 0; i < 600 && (iReq_a || iReq_b); i++) begin
         @(negedge iClk);
         if (oAck_a === 1'b1) iReq_a = 1'b0;
         if (oAck_b === 1'b1) iReq_b = 1'b0;
      end
      chk("contend_both_acked", 32'({iReq_a, iReq_b}), 0);
      waitFrames(3);
      chk("contend_first_a", 32'(ackOrder[1]), 0);
      chk("contend_second_b", 32'(ackOrder[2]), 1);
      chk("back_to_back_gap", 32'(startQ[2] - startQ[1]), 32'(BIT_CYC * FRAME));

      aData[0] = 8'h11; aData[1] = 8'h13;
      bData[0] = 8'h22; bData[1] = 8'h24;
      expQ.push_back(8'h11); expQ.push_back(8'h22);
      expQ.push_back(8'h13); expQ.push_back(8'h24);
      idxA = 0; idxB = 0;
      @(negedge iClk);
      iReq_a = 1'b1; iData_a = aData[0];
      iReq_b = 1'b1; iData_b = bData[0];
      for (int i = 0; i < 1200 && (iReq_a || iReq_b); i++) begin
         @(negedge iClk);
         if (oAck_a === 1'b1) begin
            idxA++;
            if (idxA < 2) iData_a = aData[idxA]; else iReq_a = 1'b0;
         end
         if (oAck_b === 1'b1) begin
            idxB++;
            if (idxB < 2) iData_b = bData[idxB]; else iReq_b = 1'b0;
         end
      end
      waitFrames(7);
      chk("rr_order_0", 32'(ackOrder[3]), 0);
      chk("rr_order_1", 32'(ackOrder[4]), 1);
      chk("rr_order_2", 32'(ackOrder[5]), 0);
      chk("rr_order_3", 32'(ackOrder[6]), 1);
      chk("rr_no_gap", 32'(startQ[6] - startQ[3]), 32'(3 * BIT_CYC * FRAME));

      base = 7;
`ifdef UART_TX_PARITY_EN
      sendOne(1'b0, 8'h07);
      waitFrames(8);
      chk("parity_07", 32'(lastPar), 1);
      sendOne(1'b0, 8'h03);
      waitFrames(9);
      chk("parity_03", 32'(lastPar), 0);
      base = 9;
`endif

      sendOne(1'b0, 8'h00);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge iClk);
         if (oTx === 1'b0) got = 1'b1;
      end
      chk("abort_frame_started", 32'(got), 1);
      repeat (BIT_CYC * 4 + 8) @(negedge iClk);
      chk("data_bit3_low", 32'(oTx), 0);
      #3 iRst = 1'b0;
      iReq_b = 1'b1; iData_b = 8'hA5;
      #1;
      chk("abort_tx_high", 32'(oTx), 1);
      chk("abort_busy_low", 32'(oBusy), 0);
      repeat (3) @(negedge iClk);
      expQ.push_back(8'hA5);
      iRst = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge iClk);
         if (oAck_b === 1'b1) got = 1'b1;
      end
      iReq_b = 1'b0;
      chk("post_reset_ack_b", 32'(got), 1);
      waitFrames(base + 1);
      chk("scoreboard_empty", 32'(expQ.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
